// File: rtl/lock_pkg.sv
// lock_pkg: shared keypad/lock types (FSM states, 4-bit BCD digit width, debounce/frame defaults, BCD check)
package lock_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_SHIFT, S_WAIT_REL} ser_state_e;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int DIGITS_DEF = 4;
  localparam int DIGIT_W = 4;
  localparam int DCNT_W = 2;
  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= 4'd9;
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: counts consecutive cycles i_level==i_pol while i_en; o_stable flags the cycle the count reaches DEB_CYCLES (clk, rst active-low async)
module key_debounce
  import lock_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_pol,
  input  logic i_level,
  output logic o_stable
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic w_match;
  assign w_match = i_level == i_pol;
  assign o_stable = w_match && (r_cnt >= CW'(DEB_CYCLES - 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else r_cnt <= (i_en && w_match) ? (o_stable ? CW'(DEB_CYCLES) : r_cnt + 1'b1) : '0;
  end
endmodule

// File: rtl/key_serializer.sv
// key_serializer: debounced keypad digit -> MSB-first serial bits (ser_out/ser_valid), frame_done per DIGITS digits, digit_cnt, key_err, busy; clear aborts; rst active-low async
module key_serializer
  import lock_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] key_code,
  input  logic               key_press,
  input  logic               clear,
  output logic               ser_out,
  output logic               ser_valid,
  output logic               frame_done,
  output logic [DCNT_W-1:0]  digit_cnt,
  output logic               key_err,
  output logic               busy
);
  ser_state_e r_state, w_next;
  logic [DIGIT_W-1:0] r_code;
  logic [1:0] r_bit;
  logic [DCNT_W-1:0] r_digit;
  logic r_frame_done, r_key_err;
  logic w_deb_en, w_deb_pol, w_stable, w_latch, w_last;
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk(clk),
    .rst(rst),
    .i_en(w_deb_en),
    .i_pol(w_deb_pol),
    .i_level(key_press),
    .o_stable(w_stable)
  );
  always_comb begin
    w_next = r_state;
    w_deb_pol = r_state != S_WAIT_REL;
    w_deb_en = 1'b0;
    w_latch = 1'b0;
    w_last = 1'b0;
    if (!clear) begin
      case (r_state)
        S_IDLE: begin
          w_deb_en = 1'b1;
          w_next = key_press ? S_DEBOUNCE : S_IDLE;
        end
        S_DEBOUNCE: begin
          w_deb_en = !w_stable;
          w_latch = w_stable;
          w_next = !key_press ? S_IDLE : w_stable ? (is_bcd(key_code) ? S_SHIFT : S_WAIT_REL) : S_DEBOUNCE;
        end
        S_SHIFT: begin
          w_last = r_bit == 2'd3;
          w_next = w_last ? S_WAIT_REL : S_SHIFT;
        end
        S_WAIT_REL: begin
          w_deb_en = !w_stable;
          w_next = w_stable ? S_IDLE : S_WAIT_REL;
        end
        default: w_next = S_IDLE;
      endcase
    end else begin
      w_next = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_code <= '0;
      r_bit <= '0;
      r_digit <= '0;
      r_frame_done <= 1'b0;
      r_key_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_code <= w_latch ? key_code : r_code;
      r_bit <= (r_state == S_SHIFT && !clear) ? r_bit + 2'd1 : 2'd0;
      r_digit <= clear ? '0 : w_last ? (r_digit == DCNT_W'(DIGITS - 1) ? '0 : r_digit + 1'b1) : r_digit;
      r_frame_done <= w_last && r_digit == DCNT_W'(DIGITS - 1);
      r_key_err <= w_latch && !is_bcd(key_code);
    end
  end
  assign ser_valid = r_state == S_SHIFT && !clear;
  assign ser_out = ser_valid && r_code[2'd3 - r_bit];
  assign frame_done = r_frame_done;
  assign key_err = r_key_err;
  assign digit_cnt = r_digit;
  assign busy = r_state != S_IDLE;
endmodule
